// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel packing path.
package pixel_pkg;

  localparam int unsigned PIX_IN_W  = 12;
  localparam int unsigned PIX_OUT_W = 8;
  localparam int unsigned LANES     = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    ACTIVE,
    DROP
  } state_t;

  typedef enum logic [1:0] {
    SEL_HI  = 2'd0,
    SEL_MID = 2'd1,
    SEL_LO  = 2'd2,
    SEL_SAT = 2'd3
  } bit_sel_t;

endpackage

// File: rtl/pix_trunc.sv
// Combinational 12-to-8 bit window select with optional saturation.
module pix_trunc
  import pixel_pkg::*;
(
  input  logic [PIX_IN_W-1:0]  pix,
  input  logic [1:0]           bit_sel,
  output logic [PIX_OUT_W-1:0] pix_out
);

  always_comb begin
    pix_out = pix[11:4];
    case (bit_sel_t'(bit_sel))
      SEL_HI:  pix_out = pix[11:4];
      SEL_MID: pix_out = pix[9:2];
      SEL_LO:  pix_out = pix[7:0];
      SEL_SAT: pix_out = (|pix[11:10]) ? '1 : pix[9:2];
      default: pix_out = pix[11:4];
    endcase
  end

endmodule

// File: rtl/pixel_pack_ctrl.sv
// Packs eight 12-bit pixel lanes into 64-bit FIFO words with SOF/EOL tagging,
// line/frame counting, line-length and overflow checking.
module pixel_pack_ctrl
  import pixel_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = 128,
  parameter int unsigned CNT_W          = 12
) (
  input  logic                clk_rxg,
  input  logic                rst_rx_n,
  input  logic [PIX_IN_W-1:0] datapar_in0,
  input  logic [PIX_IN_W-1:0] datapar_in1,
  input  logic [PIX_IN_W-1:0] datapar_in2,
  input  logic [PIX_IN_W-1:0] datapar_in3,
  input  logic [PIX_IN_W-1:0] datapar_in4,
  input  logic [PIX_IN_W-1:0] datapar_in5,
  input  logic [PIX_IN_W-1:0] datapar_in6,
  input  logic [PIX_IN_W-1:0] datapar_in7,
  input  logic                fvals,
  input  logic                lvals,
  input  logic [1:0]          bit_sel,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic [63:0]         fifo_din,
  output logic                fifo_sof,
  output logic                fifo_eol,
  output logic                frame_done,
  output logic [CNT_W-1:0]    frame_cnt,
  output logic [CNT_W-1:0]    line_cnt,
  output logic                err_line_len,
  output logic                err_overflow
);

  localparam int unsigned BEAT_W = $clog2(WORDS_PER_LINE) + 1;

  logic [PIX_IN_W-1:0] lane_in [LANES];
  logic [63:0]         packed_word;

  assign lane_in[0] = datapar_in0;
  assign lane_in[1] = datapar_in1;
  assign lane_in[2] = datapar_in2;
  assign lane_in[3] = datapar_in3;
  assign lane_in[4] = datapar_in4;
  assign lane_in[5] = datapar_in5;
  assign lane_in[6] = datapar_in6;
  assign lane_in[7] = datapar_in7;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pix_trunc u_trunc (
      .pix     (lane_in[g]),
      .bit_sel (bit_sel),
      .pix_out (packed_word[g*PIX_OUT_W +: PIX_OUT_W])
    );
  end

  state_t            state, state_next;
  logic              fvals_q, beat_q;
  logic              hold_valid, hold_sof, sof_armed;
  logic [63:0]       hold_data;
  logic [BEAT_W-1:0] beat_cnt;

  logic beat, fvals_rise, fvals_fall;
  logic frame_start, frame_end, take, line_end;
  logic overflow, do_write, len_bad;

  always_comb begin
    beat        = fvals & lvals;
    fvals_rise  = fvals & ~fvals_q;
    fvals_fall  = ~fvals & fvals_q;
    frame_start = (state == WAIT_FRAME) & fvals_rise;
    frame_end   = ((state == ACTIVE) | (state == DROP)) & fvals_fall;
    // A beat coinciding with the fvals rise belongs to the new frame.
    take        = beat & ((state == ACTIVE) | frame_start);
    // Covers both an lvals fall and fvals dropping while lvals is still high.
    line_end    = (state == ACTIVE) & beat_q & ~beat;
    overflow    = (take & fifo_full) | (line_end & hold_valid & fifo_full);
    do_write    = hold_valid & ~fifo_full & (take | line_end);
    len_bad     = line_end & ((beat_cnt != BEAT_W'(WORDS_PER_LINE)) | lvals);
  end

  always_ff @(posedge clk_rxg) begin
    if (!rst_rx_n) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (!fvals) state_next = WAIT_FRAME;
      WAIT_FRAME: if (fvals_rise) state_next = overflow ? DROP : ACTIVE;
      ACTIVE: begin
        if (frame_end)     state_next = WAIT_FRAME;
        else if (overflow) state_next = DROP;
      end
      DROP:       if (frame_end) state_next = WAIT_FRAME;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_rxg) begin
    if (!rst_rx_n) begin
      fvals_q      <= 1'b0;
      beat_q       <= 1'b0;
      hold_valid   <= 1'b0;
      hold_sof     <= 1'b0;
      hold_data    <= '0;
      sof_armed    <= 1'b0;
      beat_cnt     <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_din     <= '0;
      fifo_sof     <= 1'b0;
      fifo_eol     <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
      line_cnt     <= '0;
      err_line_len <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      fvals_q    <= fvals;
      beat_q     <= beat;
      fifo_wr_en <= do_write;
      fifo_sof   <= do_write & hold_sof;
      fifo_eol   <= do_write & line_end;
      frame_done <= frame_end;
      if (do_write)  fifo_din  <= hold_data;
      if (frame_end) frame_cnt <= frame_cnt + 1'b1;

      if (frame_start) begin
        line_cnt     <= '0;
        err_line_len <= 1'b0;
        err_overflow <= 1'b0;
        sof_armed    <= 1'b1;
      end
      if (line_end && line_cnt != '1) line_cnt <= line_cnt + 1'b1;
      if (len_bad)  err_line_len <= 1'b1;
      if (overflow) err_overflow <= 1'b1;

      if (take && !fifo_full) begin
        hold_data  <= packed_word;
        hold_valid <= 1'b1;
        hold_sof   <= frame_start | sof_armed;
        sof_armed  <= 1'b0;
        if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
      end else if (line_end || overflow || state != ACTIVE) begin
        hold_valid <= 1'b0;
        beat_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_pack_ctrl.sv
// Directed-vector bench for pixel_pack_ctrl with hand-computed expectations.
module tb_pixel_pack_ctrl;

  logic        clk = 1'b0;
  logic        rst_rx_n;
  logic [11:0] lanes [8];
  logic        fvals, lvals, fifo_full;
  logic [1:0]  bit_sel;
  logic        fifo_wr_en, fifo_sof, fifo_eol, frame_done;
  logic [63:0] fifo_din;
  logic [11:0] frame_cnt, line_cnt;
  logic        err_line_len, err_overflow;

  always #5 clk = ~clk;

  pixel_pack_ctrl #(.WORDS_PER_LINE(128), .CNT_W(12)) dut (
    .clk_rxg      (clk),
    .rst_rx_n     (rst_rx_n),
    .datapar_in0  (lanes[0]),
    .datapar_in1  (lanes[1]),
    .datapar_in2  (lanes[2]),
    .datapar_in3  (lanes[3]),
    .datapar_in4  (lanes[4]),
    .datapar_in5  (lanes[5]),
    .datapar_in6  (lanes[6]),
    .datapar_in7  (lanes[7]),
    .fvals        (fvals),
    .lvals        (lvals),
    .bit_sel      (bit_sel),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_din     (fifo_din),
    .fifo_sof     (fifo_sof),
    .fifo_eol     (fifo_eol),
    .frame_done   (frame_done),
    .frame_cnt    (frame_cnt),
    .line_cnt     (line_cnt),
    .err_line_len (err_line_len),
    .err_overflow (err_overflow)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int          wr_n, sof_n, eol_n, done_n, data_err, zone_wr;
  logic        chk_data, no_wr_zone;
  logic [63:0] exp_word, last_din;
  logic [11:0] nom_tab [8] = '{12'h123, 12'h234, 12'h345, 12'h456,
                               12'h567, 12'h678, 12'h789, 12'h8A0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      wr_n++;
      if (fifo_sof) sof_n++;
      if (fifo_eol) eol_n++;
      if (chk_data && fifo_din !== exp_word) data_err++;
      if (no_wr_zone) zone_wr++;
      last_din = fifo_din;
    end
    if (frame_done === 1'b1) done_n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wr_n = 0; sof_n = 0; eol_n = 0; done_n = 0; data_err = 0; zone_wr = 0;
  endtask

  task automatic nom_lanes();
    for (int unsigned i = 0; i < 8; i++) lanes[i] = nom_tab[i];
  endtask

  task automatic frame_begin();
    fvals = 1'b1; lvals = 1'b0;
    tick();
  endtask

  task automatic frame_end();
    fvals = 1'b0; lvals = 1'b0;
    tick();
    check("frame_done_pulse", 64'(frame_done), 64'd1);
    tick();
  endtask

  task automatic drive_line(input int n, input int full_at, input bit lat_chk);
    for (int i = 0; i < n; i++) begin
      fvals = 1'b1; lvals = 1'b1; fifo_full = (i == full_at);
      tick();
      if (lat_chk && i == 0) check("lat_beat0_no_wr", 64'(fifo_wr_en), 64'd0);
      if (lat_chk && i == 1) check("lat_beat1_wr_sof", 64'({fifo_wr_en, fifo_sof}), 64'd3);
    end
    lvals = 1'b0; fifo_full = 1'b0;
    tick();
  endtask

  initial begin
    rst_rx_n = 1'b0; fvals = 1'b0; lvals = 1'b0; fifo_full = 1'b0; bit_sel = 2'd0;
    chk_data = 1'b0; no_wr_zone = 1'b0; exp_word = '0; last_din = '0;
    nom_lanes();
    clr();
    repeat (3) tick();
    check("rst_din", fifo_din, 64'd0);
    check("rst_flags", 64'({fifo_wr_en, fifo_sof, fifo_eol, frame_done, err_line_len, err_overflow}), 64'd0);
    check("rst_cnts", 64'({frame_cnt, line_cnt}), 64'd0);
    rst_rx_n = 1'b1;
    tick();

    // Nominal 8x128 frame, bit_sel=0
    clr(); chk_data = 1'b1; exp_word = 64'h8A78_6756_4534_2312;
    frame_begin();
    for (int l = 0; l < 8; l++) begin
      drive_line(128, -1, l == 0);
      if (l == 0) check("eol_flush_after_fall", 64'({fifo_wr_en, fifo_eol}), 64'd3);
    end
    frame_end();
    check("nom_writes", 64'(wr_n), 64'd1024);
    check("nom_sof", 64'(sof_n), 64'd1);
    check("nom_eol", 64'(eol_n), 64'd8);
    check("nom_data_err", 64'(data_err), 64'd0);
    check("nom_line_cnt", 64'(line_cnt), 64'd8);
    check("nom_done", 64'(done_n), 64'd1);
    check("nom_frame_cnt", 64'(frame_cnt), 64'd1);
    check("nom_errs", 64'({err_line_len, err_overflow}), 64'd0);

    // Window select: saturate, mid and low windows
    clr(); bit_sel = 2'd3;
    for (int unsigned i = 0; i < 8; i++) lanes[i] = 12'h000;
    lanes[0] = 12'hC00; lanes[1] = 12'h3FC; lanes[2] = 12'h0FC;
    exp_word = 64'h0000_0000_003F_FFFF;
    frame_begin(); drive_line(128, -1, 0); frame_end();
    check("sat_data_err", 64'(data_err), 64'd0);
    check("sat_last_word", last_din, 64'h0000_0000_003F_FFFF);
    check("sat_writes", 64'(wr_n), 64'd128);
    chk_data = 1'b0; bit_sel = 2'd1;
    for (int unsigned i = 0; i < 8; i++) lanes[i] = 12'hABC;
    frame_begin(); drive_line(2, -1, 0); frame_end();
    check("mid_window", last_din, 64'hAFAF_AFAF_AFAF_AFAF);
    check("len_err_2beats", 64'(err_line_len), 64'd1);
    bit_sel = 2'd2;
    frame_begin(); drive_line(2, -1, 0); frame_end();
    check("lo_window", last_din, 64'hBCBC_BCBC_BCBC_BCBC);
    check("frame_cnt_4", 64'(frame_cnt), 64'd4);

    // Short line followed by a normal line
    clr(); bit_sel = 2'd0; nom_lanes(); chk_data = 1'b1; exp_word = 64'h8A78_6756_4534_2312;
    frame_begin();
    check("sof_clears_len_err", 64'(err_line_len), 64'd0);
    drive_line(127, -1, 0);
    check("short_len_err", 64'(err_line_len), 64'd1);
    drive_line(128, -1, 0);
    frame_end();
    check("short_eol", 64'(eol_n), 64'd2);
    check("short_line_cnt", 64'(line_cnt), 64'd2);
    check("short_writes", 64'(wr_n), 64'd255);
    check("short_len_sticky", 64'(err_line_len), 64'd1);

    // Overflow at beat 40 of line 2
    clr();
    frame_begin();
    drive_line(128, -1, 0);
    drive_line(128, 40, 0);
    check("ovf_flag", 64'(err_overflow), 64'd1);
    no_wr_zone = 1'b1;
    drive_line(128, -1, 0);
    frame_end();
    no_wr_zone = 1'b0;
    check("ovf_no_wr_after", 64'(zone_wr), 64'd0);
    check("ovf_writes", 64'(wr_n), 64'd167);
    check("ovf_eol", 64'(eol_n), 64'd1);
    check("ovf_line_cnt", 64'(line_cnt), 64'd1);
    check("ovf_done", 64'(done_n), 64'd1);
    clr();
    frame_begin();
    check("ovf_cleared_at_sof", 64'(err_overflow), 64'd0);
    drive_line(128, -1, 0);
    frame_end();
    check("ovf_next_writes", 64'(wr_n), 64'd128);
    check("ovf_next_sof", 64'(sof_n), 64'd1);
    check("ovf_next_flag", 64'(err_overflow), 64'd0);

    // Truncated frame: fvals drops during beat 60's line
    clr(); chk_data = 1'b0;
    frame_begin();
    for (int i = 0; i <= 60; i++) begin
      fvals = 1'b1; lvals = 1'b1; lanes[0] = 12'(i * 16);
      tick();
    end
    fvals = 1'b0;
    tick();
    check("trunc_wr_eol", 64'({fifo_wr_en, fifo_eol}), 64'd3);
    check("trunc_byte0", 64'(fifo_din[7:0]), 64'h3C);
    check("trunc_done", 64'(frame_done), 64'd1);
    check("trunc_len_err", 64'(err_line_len), 64'd1);
    check("trunc_line_cnt", 64'(line_cnt), 64'd1);
    lvals = 1'b0;
    tick(); tick();
    check("trunc_writes", 64'(wr_n), 64'd61);

    // Reset in the middle of line 3 with fvals held high
    nom_lanes(); chk_data = 1'b1;
    frame_begin();
    drive_line(128, -1, 0);
    drive_line(128, -1, 0);
    for (int i = 0; i < 10; i++) begin lvals = 1'b1; tick(); end
    rst_rx_n = 1'b0;
    tick();
    check("mid_rst_flags", 64'({fifo_wr_en, fifo_sof, fifo_eol, frame_done, err_line_len, err_overflow}), 64'd0);
    check("mid_rst_cnts", 64'({frame_cnt, line_cnt}), 64'd0);
    tick();
    rst_rx_n = 1'b1;
    clr();
    for (int i = 0; i < 20; i++) tick();
    lvals = 1'b0; tick(); lvals = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    lvals = 1'b0; tick();
    check("mid_rst_no_writes", 64'(wr_n), 64'd0);
    fvals = 1'b0;
    tick();
    check("mid_rst_no_done", 64'(frame_done), 64'd0);
    tick();
    frame_begin();
    drive_line(128, -1, 0);
    frame_end();
    check("mid_rst_next_writes", 64'(wr_n), 64'd128);
    check("mid_rst_next_sof", 64'(sof_n), 64'd1);
    check("mid_rst_frame_cnt", 64'(frame_cnt), 64'd1);
    check("mid_rst_data_err", 64'(data_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
